booth_mul_arbiter: RTL
======================

# booth_mul_arbiter

Sequencer and round-robin arbiter that shares one `boothe` Booth multiplier datapath between `NREQ` requesters. It grants one requester at a time, muxes its operands onto the datapath's single `data_in` bus, and drives every datapath control strobe through clear, load and N add/sub/shift iterations. It then captures the 2N-bit signed product and returns it to the granted requester with a one-cycle response pulse. It replaces the standalone `controlpath` when the multiplier is a shared resource.

## Interface
- `N`, 9: operand width; must match the datapath `N`.
- `NREQ`, 4: number of requesters, 2..8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester request level.
- `opa`  in  NREQ*N  multiplicands, flattened; requester i uses bits [i*N+N-1:i*N].
- `opb`  in  NREQ*N  multipliers, flattened, same packing.
- `ack`  out  NREQ  one-hot grant; stays high from grant until the response cycle inclusive.
- `rsp_valid`  out  1  one-cycle result pulse.
- `rsp_id`  out  clog2(NREQ)  index of the served requester, valid with `rsp_valid`.
- `rsp_prod`  out  2N  signed product, valid with `rsp_valid`, held until the next response.
- `busy`  out  1  high in every state except IDLE.
- `dp_clr`, `dp_clr_f`, `dp_ld_cnt`, `dp_ld_q`, `dp_ld_p`, `dp_ld_r`, `dp_shift`, `dp_ld`, `dp_dec`  out  1 each  datapath control strobes.
- `dp_data_in`  out  N  datapath operand bus.
- `dp_add`, `dp_sub`, `dp_eqz`  in  1 each  datapath status.
- `dp_out`  in  2N  datapath accumulator/product.

## Operation
- States: IDLE, CLEAR, LOADQ, LOADP, STEP, CAPT, RESP. Encoding is binary and registered.
- IDLE: if any `req` bit is high, grant the first requesting index at or above `rr_ptr`, wrapping. Latch the grant index and go to CLEAR. If no `req` bit is high, stay in IDLE.
- CLEAR: assert `dp_clr`, `dp_clr_f`, `dp_ld_cnt`. Go to LOADQ.
- LOADQ: drive `dp_data_in` = opb[grant]; assert `dp_ld_q`. Go to LOADP.
- LOADP: drive `dp_data_in` = opa[grant]; assert `dp_ld_p`. Go to STEP.
- STEP, when `dp_eqz` is low: assert `dp_dec` and `dp_ld`. Also assert `dp_ld_r` = `dp_add`|`dp_sub` and `dp_shift` = the inverse of that. Stay in STEP.
- STEP, when `dp_eqz` is high: assert no strobes; go to CAPT.
- CAPT: register `dp_out` into `rsp_prod`. Go to RESP.
- RESP: `rsp_valid`=1. Set `rr_ptr` = (grant+1) mod NREQ. Drop `ack` at the end of this cycle. Go to IDLE.
- Outside their states, all `dp_*` strobes are 0 and `dp_data_in` is 0.
- Operands are latched at the LOADQ/LOADP edges. The requester must hold `req`, `opa` and `opb` stable until `ack` goes high, and operands until LOADP completes. Holding them until `rsp_valid` is sufficient.
- A `req` dropped while its `ack` is high is ignored; the operation completes and responds.
- Arithmetic: two's-complement N×N to 2N-bit. The most negative operand (−2^(N−1)) is supported.

## Timing
- Reset: state=IDLE; `rr_ptr`=0; `ack`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_prod`=0, `busy`=0; all `dp_*` outputs 0.
- `clr` asserted mid-operation aborts on the next edge with the same values as reset. No response is issued for the aborted operation.
- Latency: `req` sampled in IDLE at edge 0. Then CLEAR runs in cycle 1, LOADQ in cycle 2, LOADP in cycle 3, and STEP in cycles 4..N+4 (N+1 cycles). CAPT is cycle N+5, RESP is cycle N+6. For N=9, `rsp_valid` is high in cycle 15.
- Throughput: one product per N+7 cycles. A new grant is possible at the edge that leaves RESP+IDLE, so back-to-back operations are N+7 cycles apart.
- Simultaneous requests: round-robin from `rr_ptr`. A requester re-asserting immediately after its own response has the lowest priority.

## Configuration
- `BOOTH_ARB_ZERO_BYPASS_EN` defined: in IDLE, if the granted opa or opb is 0, skip CLEAR through CAPT and go directly to RESP with `rsp_prod`=0. `rsp_valid` is then high in cycle 1. No datapath strobes are asserted.
- `BOOTH_ARB_ZERO_BYPASS_EN` undefined: every grant runs the full sequence, and zero products take N+6 cycles.

## Test plan
- Reset during STEP (cycle 8): state returns to IDLE next edge; all outputs 0; no `rsp_valid`; `rr_ptr`=0.
- Single request, N=9: req=0001, opa=7, opb=−3 -> `ack`=0001 from cycle 1. Then `rsp_valid` in cycle 15 with `rsp_id`=0 and `rsp_prod`=18'h3FFEB (−21).
- Signed corners: (−256)×(−256) -> 18'h10000. 255×(−256) -> 18'h30100. (−1)×(−1) -> 18'h00001.
- Round robin: req=1011 held continuously -> served in order 0,1,3,0. Each `rsp_valid` is 16 cycles apart, with ids 0,1,3,0.
- Strobe check: opb=0x0AA -> STEP cycles alternate `dp_ld_r` and `dp_shift` according to `dp_add`/`dp_sub`. `dp_dec` is high exactly 9 cycles.
- Zero operand: opa=0, opb=5. With the macro defined -> `rsp_valid` in cycle 1 with product 0 and no `dp_*` strobes. Without the macro -> `rsp_valid` in cycle 15 with product 0.

Source files
------------

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
//   Round-robin arbiter and sequencer that shares one Booth multiplier
//   datapath between NREQ requesters. One requester is granted at a time.
//   Its operands are muxed onto dp_data_in and the datapath is stepped
//   through clear, load and N add/sub/shift iterations. The 2N-bit product
//   is then returned with a one-cycle rsp_valid pulse.
//
// Parameters
//   N     operand width (must match the datapath)
//   NREQ  number of requesters, 2..8
//
// Ports
//   clk, clr              clock, synchronous active-high reset
//   req/opa/opb           per-requester request level and flattened operands
//   ack                   one-hot grant, high from grant through the response cycle
//   rsp_valid/id/prod     result pulse, served index, signed product (held)
//   busy                  high in every state except IDLE
//   dp_*  (out)           datapath control strobes and operand bus
//   dp_add/sub/eqz/out    datapath status and accumulator/product
//
// Optional feature
//   BOOTH_ARB_ZERO_BYPASS_EN : a grant whose opa or opb is zero skips the
//   datapath entirely and responds with a zero product in cycle 1.
//
// States
//   IDLE  | waiting for a request; arbitration happens here
//   CLEAR | clear accumulator and Q-1 flop, load the iteration counter
//   LOADQ | multiplier (opb) onto the datapath
//   LOADP | multiplicand (opa) onto the datapath
//   STEP  | one add/sub-or-shift iteration per cycle until the counter hits 0
//   CAPT  | register the datapath product
//   RESP  | response pulse, advance the round-robin pointer

module booth_mul_arbiter #(
  parameter int N    = 9,
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*N-1:0]        opa,
  input  logic [NREQ*N-1:0]        opb,
  output logic [NREQ-1:0]          ack,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [2*N-1:0]           rsp_prod,
  output logic                     busy,
  output logic                     dp_clr,
  output logic                     dp_clr_f,
  output logic                     dp_ld_cnt,
  output logic                     dp_ld_q,
  output logic                     dp_ld_p,
  output logic                     dp_ld_r,
  output logic                     dp_shift,
  output logic                     dp_ld,
  output logic                     dp_dec,
  output logic [N-1:0]             dp_data_in,
  input  logic                     dp_add,
  input  logic                     dp_sub,
  input  logic                     dp_eqz,
  input  logic [2*N-1:0]           dp_out
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOADQ = 3'd2,
    S_LOADP = 3'd3,
    S_STEP  = 3'd4,
    S_CAPT  = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] grant;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick;
  logic          found;
  logic [N-1:0]  sel_a, sel_b;
  int            cand;

  // Round-robin search: first requesting index at or above rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (i == cand)) begin
          found = 1'b1;
          pick  = IW'(i);
        end
      end
    end
  end

  // Operand mux for the latched grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IW'(i)) begin
        sel_a = opa[i*N +: N];
        sel_b = opb[i*N +: N];
      end
    end
  end

`ifdef BOOTH_ARB_ZERO_BYPASS_EN
  logic [N-1:0] pick_a, pick_b;
  logic         pick_zero;

  // Operands of the requester about to be granted, checked before the grant.
  always_comb begin
    pick_a = '0;
    pick_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IW'(i)) begin
        pick_a = opa[i*N +: N];
        pick_b = opb[i*N +: N];
      end
    end
    pick_zero = (pick_a == '0) || (pick_b == '0);
  end
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      rsp_prod <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && found) grant <= pick;
      if (state == S_CAPT) rsp_prod <= dp_out;
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
      if (state == S_IDLE && found && pick_zero) rsp_prod <= '0;
`endif
      if (state == S_RESP) begin
        rr_ptr <= (grant == IW'(NREQ-1)) ? '0 : grant + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    dp_clr     = 1'b0;
    dp_clr_f   = 1'b0;
    dp_ld_cnt  = 1'b0;
    dp_ld_q    = 1'b0;
    dp_ld_p    = 1'b0;
    dp_ld_r    = 1'b0;
    dp_shift   = 1'b0;
    dp_ld      = 1'b0;
    dp_dec     = 1'b0;
    dp_data_in = '0;
    rsp_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
          state_nx = pick_zero ? S_RESP : S_CLEAR;
`else
          state_nx = S_CLEAR;
`endif
        end
      end
      S_CLEAR: begin
        dp_clr    = 1'b1;
        dp_clr_f  = 1'b1;
        dp_ld_cnt = 1'b1;
        state_nx  = S_LOADQ;
      end
      S_LOADQ: begin
        dp_data_in = sel_b;
        dp_ld_q    = 1'b1;
        state_nx   = S_LOADP;
      end
      S_LOADP: begin
        dp_data_in = sel_a;
        dp_ld_p    = 1'b1;
        state_nx   = S_STEP;
      end
      S_STEP: begin
        if (!dp_eqz) begin
          dp_dec   = 1'b1;
          dp_ld    = 1'b1;
          // Booth pair 01/10 needs an add/sub; 00/11 is a pure shift.
          dp_ld_r  = dp_add | dp_sub;
          dp_shift = ~(dp_add | dp_sub);
        end else begin
          state_nx = S_CAPT;
        end
      end
      S_CAPT: state_nx = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy   = (state != S_IDLE);
  assign rsp_id = grant;

  always_comb begin
    ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack[i] = busy && (grant == IW'(i));
    end
  end

endmodule
